// File: rtl/keypad_lock.sv
// Keypad code-entry controller: assembles a BCD code from press pulses, unlocks on
// a matching hash, allows code change while unlocked, and locks out after repeated failures.
module keypad_lock #(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] INIT_CODE   = 16'h1234,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCKOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            i_button,
    input  logic                  i_star,
    input  logic                  i_hash,
    output logic                  o_unlocked,
    output logic                  o_fail,
    output logic                  o_saved,
    output logic                  o_locked_out,
    output logic [2:0]            o_digit_cnt,
    output logic [4*DIGITS-1:0]   o_entry
);

    localparam int CODE_W = 4 * DIGITS;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [2:0]        DIG_C   = 3'(DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_C  = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  TMR_TOP = TMR_W'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNLOCKED = 2'd1,
        SET      = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [CODE_W-1:0]   code, code_nxt;
    logic [CODE_W-1:0]   entry, entry_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic [FAIL_W-1:0]   fail_cnt, fail_nxt, fail_inc;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                fail_pulse, saved_pulse;

    logic [11:0]         ev;
    logic                single;
    logic                is_digit, is_star, is_hash;
    logic [3:0]          dig;

    // Exactly one press in a cycle forms an event; simultaneous presses are dropped.
    assign ev       = {i_hash, i_star, i_button};
    assign single   = (ev != 12'd0) && ((ev & (ev - 12'd1)) == 12'd0);
    assign is_digit = single && (i_button != 10'd0);
    assign is_star  = single && i_star;
    assign is_hash  = single && i_hash;
    assign fail_inc = fail_cnt + 1'b1;

    always_comb begin
        dig = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (i_button[k]) dig = 4'(k);
        end
    end

    always_comb begin
        state_nxt   = state;
        code_nxt    = code;
        entry_nxt   = entry;
        cnt_nxt     = cnt;
        fail_nxt    = fail_cnt;
        timer_nxt   = timer;
        fail_pulse  = 1'b0;
        saved_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (is_digit) begin
                    if (cnt < DIG_C) begin
                        entry_nxt = {entry[CODE_W-5:0], dig};
                        cnt_nxt   = cnt + 3'd1;
                    end
                end else if (is_star) begin
                    entry_nxt = '0;
                    cnt_nxt   = 3'd0;
                end else if (is_hash) begin
                    if (cnt == DIG_C && entry == code) begin
                        state_nxt = UNLOCKED;
                        fail_nxt  = '0;
                    end else begin
                        fail_pulse = 1'b1;
                        fail_nxt   = fail_inc;
                        entry_nxt  = '0;
                        cnt_nxt    = 3'd0;
                        if (fail_inc == FAIL_C) begin
                            state_nxt = LOCKOUT;
                            timer_nxt = TMR_TOP;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (is_hash || is_star) begin
                    state_nxt = is_hash ? IDLE : SET;
                    entry_nxt = '0;
                    cnt_nxt   = 3'd0;
                end
            end
            SET: begin
                if (is_digit) begin
                    if (cnt < DIG_C) begin
                        entry_nxt = {entry[CODE_W-5:0], dig};
                        cnt_nxt   = cnt + 3'd1;
                    end
                end else if (is_star) begin
                    state_nxt = UNLOCKED;
                    entry_nxt = '0;
                    cnt_nxt   = 3'd0;
                end else if (is_hash) begin
                    entry_nxt = '0;
                    cnt_nxt   = 3'd0;
                    if (cnt == DIG_C) begin
                        code_nxt    = entry;
                        saved_pulse = 1'b1;
                        state_nxt   = UNLOCKED;
                    end else begin
                        fail_pulse = 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                entry_nxt = '0;
                cnt_nxt   = 3'd0;
                if (timer == '0) begin
                    state_nxt = IDLE;
                    fail_nxt  = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            code         <= INIT_CODE;
            entry        <= '0;
            cnt          <= 3'd0;
            fail_cnt     <= '0;
            timer        <= '0;
            o_unlocked   <= 1'b0;
            o_fail       <= 1'b0;
            o_saved      <= 1'b0;
            o_locked_out <= 1'b0;
        end else begin
            state        <= state_nxt;
            code         <= code_nxt;
            entry        <= entry_nxt;
            cnt          <= cnt_nxt;
            fail_cnt     <= fail_nxt;
            timer        <= timer_nxt;
            o_unlocked   <= (state_nxt == UNLOCKED);
            o_fail       <= fail_pulse;
            o_saved      <= saved_pulse;
            o_locked_out <= (state_nxt == LOCKOUT);
        end
    end

    assign o_digit_cnt = cnt;
    assign o_entry     = entry;

endmodule
